uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised successor UART transmitter for the RS-232 path. It serialises one frame per valid/ready handshake: start bit, 5..DATA_W data bits LSB-first, optional even/odd parity, then 1 or 2 stop bits.
- Each bit lasts OVS pulses of an external oversampling tick. The tick is a single-cycle enable synchronous to Clk, not a separate clock.
- Sits between the byte-source logic and the baud tick generator, driving the line pin directly.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9); width of TxData.
OVS, 16, Tick pulses per bit period (legal 4..64).

Ports:
Clk  in  1  system clock.
Rst  in  1  reset, asynchronous, active-high.
Tick  in  1  oversampling enable, one Clk cycle wide.
TxValid  in  1  frame request.
TxReady  out  1  block can accept a frame.
TxData  in  DATA_W  payload; bit 0 sent first.
NBits  in  4  data bits this frame.
Parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
StopBits  in  1  0 = one stop bit, 1 = two stop bits.
Tx  out  1  serial line, idle high, registered.
TxDone  out  1  one-cycle pulse at frame completion.
Busy  out  1  high from accept until the cycle TxDone pulses.

Behaviour:
- Reset (async, Rst=1): Tx=1, TxReady=0 while Rst asserted, TxDone=0, Busy=0, state IDLE, counters 0. Any frame in progress is aborted and produces no TxDone. TxReady=1 on the first Clk edge after release.
- Accept: occurs when TxValid && TxReady on a Clk edge. TxData, NBits, Parity and StopBits are latched then; later input changes are ignored until the next accept.
- TxReady is high only in IDLE. The input side must not be throttled beyond that.
- NBits clamping: values <5 use 5; values >DATA_W use DATA_W.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - PARITY is skipped when the latched Parity is 00 or 11.
  - STOP2 is skipped when the latched StopBits is 0.
- Bit timing:
  - Tick counter (0..OVS-1) increments only on Tick.
  - On Tick with counter==OVS-1, the counter wraps to 0 and the FSM advances.
  - Each bit therefore lasts exactly OVS ticks, counted from the first Tick after state entry.
- Tx levels: registered and updated on the state-entry edge.
  - START: 0. DATA: current shift-register LSB. PARITY: parity bit. STOP1/STOP2: 1. IDLE: 1.
- Latency: Tx falls on the Clk edge following the accept edge.
- Shifting: shift right once per completed data bit. A data bit counter counts to NBits-1, then the FSM leaves DATA.
- Parity bit: XOR over the NBits data bits only, inverted for odd parity.
- Completion: the final stop-bit wrap moves the FSM to IDLE and registers TxDone=1 for exactly one cycle. That same cycle shows TxReady=1 and Busy=0.
  - An accept in that cycle starts the next frame with no idle gap beyond one Clk.
- Tick asserted in IDLE or on the accept cycle: ignored; the counter is held at 0.
- TxValid dropped mid-frame: no effect.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Enabled: adds input TxBreak (1 bit).
  - TxBreak sampled high in IDLE, with no accept in the same cycle, enters state BREAK: Tx=0, TxReady=0, Busy=1.
  - On TxBreak deassert, the block drives Tx=1 for one full bit time (OVS ticks), then returns to IDLE. TxDone does not pulse.
  - TxBreak asserted mid-frame has no effect until the frame ends.
  - If TxValid and TxBreak are both high in IDLE, the frame wins.
- Disabled: port and BREAK state absent; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg:
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state typedef tx_state_t.
  - Constants NBITS_MIN=5 and NBITS_MAX=9.
- One sub-module: uart_ovs_counter, the OVS-modulo tick counter with clear input and wrap output. It is reused by the future RX block.

Test Plan:
1. OVS=16, accept 0xA5, NBits=8, Parity=00, StopBits=0 -> Tx = 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; TxDone once after 160 ticks; Busy low after.
2. TxData=0x53, NBits=8, Parity=10 (odd), StopBits=1 -> parity bit 1, then two stop bits; frame is 12 bit times; TxDone single-cycle.
3. NBits=3 with 0x1F, Parity=01 -> clamped to 5 bits 1,1,1,1,1; even parity bit 1; 8 bit times total.
4. TxValid held high with 0x00 then 0xFF -> second frame accepted on the TxDone cycle; Tx falls on the next Clk edge; no extra idle bit.
5. Rst asserted mid-data bit 3 -> Tx=1 immediately (asynchronously); no TxDone; post-reset frame 0x3C transmits correctly.
6. (UART_TX_BREAK_EN) TxBreak high for 40 ticks in IDLE -> Tx=0 for the hold; then Tx=1 for 16 ticks with TxReady=0; then TxReady=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX FSM states, frame-size limits
// and the NBits clamp helper.
package uart_pkg;

    localparam int NBITS_MIN = 5;
    localparam int NBITS_MAX = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } par_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BRK_HOLD,
        S_BRK_STOP
    } tx_state_t;

    // Requests below the minimum are raised to 5 bits.
    // Requests above max_bits are cut down to max_bits.
    function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input int unsigned max_bits);
        if (n < 4'(NBITS_MIN)) return 4'(NBITS_MIN);
        if (32'(n) > max_bits) return 4'(max_bits);
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Frame-request handshake between the byte source (master) and the UART TX (slave).
// Carries TxBreak when UART_TX_BREAK_EN is defined.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic              TxValid;
    logic              TxReady;
    logic [DATA_W-1:0] TxData;
    logic [3:0]        NBits;
    logic [1:0]        Parity;
    logic              StopBits;
`ifdef UART_TX_BREAK_EN
    logic              TxBreak;

    modport master (output TxValid, TxData, NBits, Parity, StopBits, TxBreak, input TxReady);
    modport slave  (input TxValid, TxData, NBits, Parity, StopBits, TxBreak, output TxReady);
`else
    modport master (output TxValid, TxData, NBits, Parity, StopBits, input TxReady);
    modport slave  (input TxValid, TxData, NBits, Parity, StopBits, output TxReady);
`endif
endinterface

// File: rtl/uart_ovs_counter.sv
// OVS-modulo oversampling tick counter with synchronous clear.
// Shared between the UART TX and RX paths.
module uart_ovs_counter #(
    parameter int OVS = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear_i,
    input  logic tick_i,
    output logic wrap_o
);
    localparam int CW = $clog2(OVS);

    logic [CW-1:0] cnt_q, cnt_d;

    assign wrap_o = tick_i && !clear_i && (cnt_q == CW'(OVS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)     cnt_d = '0;
        else if (wrap_o) cnt_d = '0;
        else if (tick_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, 5..DATA_W data bits LSB-first, optional parity, 1/2 stops.
// Define UART_TX_BREAK_EN to add the TxBreak line-break feature.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Tick,
    uart_tx_param_if.slave bus,
    output logic           Tx,
    output logic           TxDone,
    output logic           Busy
);
    localparam int MAX_BITS = (DATA_W < NBITS_MAX) ? DATA_W : NBITS_MAX;

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        nbits_q, nbits_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic              accept, wrap, cnt_clear, par_calc;
    logic [3:0]        nbits_lim;
    logic [DATA_W-1:0] data_masked;

    assign accept    = bus.TxValid && ready_q;
    assign nbits_lim = clamp_nbits(bus.NBits, MAX_BITS);

    // Parity covers only the bits that will actually be sent.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign data_masked[gi] = bus.TxData[gi] & (4'(gi) < nbits_lim);
    end
    assign par_calc = (^data_masked) ^ (bus.Parity == PAR_ODD);

    // Ticks in IDLE (including the accept cycle) or while a break is held do not count.
    assign cnt_clear = (state_q == S_IDLE) || (state_q == S_BRK_HOLD);

    uart_ovs_counter #(.OVS(OVS)) u_ovs (
        .Clk     (Clk),
        .Rst     (Rst),
        .clear_i (cnt_clear),
        .tick_i  (Tick),
        .wrap_o  (wrap)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            nbits_q   <= '0;
            bitcnt_q  <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            nbits_q   <= nbits_d;
            bitcnt_q  <= bitcnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        nbits_d   = nbits_q;
        bitcnt_d  = bitcnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    shift_d   = bus.TxData;
                    nbits_d   = nbits_lim;
                    bitcnt_d  = '0;
                    par_en_d  = (bus.Parity == PAR_EVEN) || (bus.Parity == PAR_ODD);
                    par_bit_d = par_calc;
                    stop2_d   = bus.StopBits;
                end
`ifdef UART_TX_BREAK_EN
                else if (bus.TxBreak) begin
                    state_d = S_BRK_HOLD;
                end
`endif
            end
            S_START:  if (wrap) state_d = S_DATA;
            S_DATA: begin
                if (wrap) begin
                    if (bitcnt_q == nbits_q - 4'd1) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            S_PARITY: if (wrap) state_d = S_STOP1;
            S_STOP1:  if (wrap) state_d = stop2_q ? S_STOP2 : S_IDLE;
            S_STOP2:  if (wrap) state_d = S_IDLE;
`ifdef UART_TX_BREAK_EN
            S_BRK_HOLD: if (!bus.TxBreak) state_d = S_BRK_STOP;
            S_BRK_STOP: if (wrap) state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so Tx changes on the state-entry edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:    tx_d = 1'b0;
            S_DATA:     tx_d = shift_d[0];
            S_PARITY:   tx_d = par_bit_d;
            S_BRK_HOLD: tx_d = 1'b0;
            default:    tx_d = 1'b1;
        endcase
        done_d  = wrap && (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    assign Tx          = tx_q;
    assign TxDone      = done_q;
    assign Busy        = busy_q;
    assign bus.TxReady = ready_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param with an expected-bit scoreboard queue.
module tb_uart_tx_param;
    localparam int DATA_W = 8;
    localparam int OVS    = 16;

    logic Clk  = 1'b0;
    logic Rst  = 1'b0;
    logic Tick = 1'b0;
    logic Tx, TxDone, Busy;

    uart_tx_param_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_param #(.DATA_W(DATA_W), .OVS(OVS)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Tick   (Tick),
        .bus    (bus.slave),
        .Tx     (Tx),
        .TxDone (TxDone),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    int   n_cmp    = 0;
    int   n_mis    = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    logic exp_q[$];

    // One-cycle Tick every 4 clocks, changing 2 time units after the edge.
    initial begin
        int div = 0;
        forever begin
            @(posedge Clk);
            #2;
            div  = (div + 1) % 4;
            Tick = (div == 0);
        end
    end

    initial forever begin
        @(negedge Clk);
        if (TxDone === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] d, input int nb, input logic [1:0] par, input logic stop);
        int   n;
        logic p;
        n = (nb < 5) ? 5 : ((nb > DATA_W) ? DATA_W : nb);
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 2'b01) exp_q.push_back(p);
        if (par == 2'b10) exp_q.push_back(~p);
        exp_q.push_back(1'b1);
        if (stop) exp_q.push_back(1'b1);
    endtask

    // Samples Tx/TxReady/Busy at every Tick for n ticks.
    task automatic check_ticks(input int n, input logic etx, input logic erdy, input logic ebsy, input string tag);
        int got    = 0;
        int budget = n * 16 + 40;
        while (got < n && budget > 0) begin
            @(negedge Clk);
            budget--;
            if (Tick) begin
                chk({tag, "_tx"}, 32'(Tx), 32'(etx));
                chk({tag, "_rdy_bsy"}, 32'({bus.TxReady, Busy}), 32'({erdy, ebsy}));
                got++;
            end
        end
        if (got < n) chk({tag, "_timeout"}, 32'(got), 32'(n));
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int nb, input logic [1:0] par,
                        input logic stop, input logic hold);
        int budget = 4000;
        bus.TxData   = d;
        bus.NBits    = 4'(nb);
        bus.Parity   = par;
        bus.StopBits = stop;
        bus.TxValid  = 1'b1;
        push_frame(d, nb, par, stop);
        while (bus.TxReady !== 1'b1 && budget > 0) begin
            @(negedge Clk);
            budget--;
        end
        if (budget == 0) chk("ready_timeout", 32'(bus.TxReady), 32'd1);
        @(posedge Clk);
        #1;
        chk("accept_tx_fall", 32'(Tx), 32'd0);
        chk("accept_busy", 32'(Busy), 32'd1);
        if (!hold) bus.TxValid = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int   k = 0;
        logic b;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check_ticks(OVS, b, 1'b0, 1'b1, $sformatf("%s_bit%0d", tag, k));
            k++;
        end
        @(posedge Clk);
        #1;
        chk({tag, "_done"}, 32'(TxDone), 32'd1);
        chk({tag, "_end_rdy_bsy"}, 32'({bus.TxReady, Busy}), 32'b10);
        chk({tag, "_end_tx"}, 32'(Tx), 32'd1);
        exp_done++;
    endtask

    task automatic check_done_count(input string tag);
        repeat (2) @(negedge Clk);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        int done_before;
        bus.TxValid  = 1'b0;
        bus.TxData   = '0;
        bus.NBits    = 4'd8;
        bus.Parity   = 2'b00;
        bus.StopBits = 1'b0;
`ifdef UART_TX_BREAK_EN
        bus.TxBreak  = 1'b0;
`endif
        // Reset state
        #1 Rst = 1'b1;
        #1;
        chk("rst_tx", 32'(Tx), 32'd1);
        chk("rst_ready", 32'(bus.TxReady), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(TxDone), 32'd0);
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk("rel_ready", 32'(bus.TxReady), 32'd1);
        repeat (20) @(negedge Clk);

        // 1: 0xA5, 8N1
        send(8'hA5, 8, 2'b00, 1'b0, 1'b0);
        check_frame("t1");
        check_done_count("t1");

        // 2: 0x53, odd parity, two stops
        send(8'h53, 8, 2'b10, 1'b1, 1'b0);
        check_frame("t2");
        check_done_count("t2");

        // 3: NBits=3 clamps to 5, even parity
        send(8'h1F, 3, 2'b01, 1'b0, 1'b0);
        check_frame("t3");
        check_done_count("t3");

        // NBits above DATA_W clamps to DATA_W; Parity=11 means none
        send(8'h81, 15, 2'b11, 1'b0, 1'b0);
        check_frame("t3b");
        check_done_count("t3b");

        // 4: TxValid held, back-to-back frames; data changed after accept is ignored
        send(8'h00, 8, 2'b00, 1'b0, 1'b1);
        bus.TxData = 8'hFF;
        check_frame("t4a");
        send(8'hFF, 8, 2'b00, 1'b0, 1'b0);
        check_frame("t4b");
        check_done_count("t4");

        // 5: reset mid data bit 3
        send(8'h96, 8, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_ticks(OVS, exp_q.pop_front(), 1'b0, 1'b1, $sformatf("t5_bit%0d", i));
        check_ticks(OVS / 2, exp_q.pop_front(), 1'b0, 1'b1, "t5_bit4_half");
        exp_q.delete();
        done_before = done_cnt;
        #2 Rst = 1'b1;
        #1;
        chk("t5_rst_tx", 32'(Tx), 32'd1);
        chk("t5_rst_rdy_bsy", 32'({bus.TxReady, Busy}), 32'b00);
        chk("t5_rst_done", 32'(TxDone), 32'd0);
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk("t5_rel_ready", 32'(bus.TxReady), 32'd1);
        chk("t5_no_done", 32'(done_cnt), 32'(done_before));
        send(8'h3C, 8, 2'b00, 1'b0, 1'b0);
        check_frame("t5");
        check_done_count("t5");

`ifdef UART_TX_BREAK_EN
        // 6: break held 40 ticks, then one idle bit time
        repeat (3) @(negedge Clk);
        bus.TxBreak = 1'b1;
        @(posedge Clk);
        #1;
        chk("t6_brk_tx", 32'(Tx), 32'd0);
        chk("t6_brk_rdy_bsy", 32'({bus.TxReady, Busy}), 32'b01);
        check_ticks(40, 1'b0, 1'b0, 1'b1, "t6_hold");
        bus.TxBreak = 1'b0;
        check_ticks(OVS, 1'b1, 1'b0, 1'b1, "t6_stop");
        @(posedge Clk);
        #1;
        chk("t6_end_rdy_bsy", 32'({bus.TxReady, Busy}), 32'b10);
        chk("t6_end_tx", 32'(Tx), 32'd1);
        check_done_count("t6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
